// File: rtl/vda_pkg.sv
// Shared types and constants for the vda command issue stage.
package vda_pkg;

  localparam int unsigned VEC_W     = 17;
  localparam int unsigned OP_LSB    = 11;
  localparam int unsigned DEF_REP_W = 4;

  // Bit map: [16:11] opcode q..l, [10:0] condition flags k..a.
  typedef logic [VEC_W-1:0] vda_vec_t;

  typedef struct packed {
    vda_vec_t              vec;
    logic [DEF_REP_W-1:0]  rep;
  } vda_cmd_t;

  typedef enum logic {
    IDLE,
    ISSUE
  } issue_state_t;

  // Opcode field q..l of a command vector.
  function automatic logic [VEC_W-OP_LSB-1:0] vda_opcode(vda_vec_t v);
    return v[VEC_W-1:OP_LSB];
  endfunction

endpackage

// File: rtl/vda_cmd_issue_if.sv
// Command-in / beat-out handshake bundle for the vda issue stage.
interface vda_cmd_issue_if
  import vda_pkg::*;
#(
  parameter int unsigned REP_W = 4
) ();

  logic             in_valid;
  logic             in_ready;
  vda_vec_t         in_vec;
  logic [REP_W-1:0] in_rep;

  logic             out_valid;
  logic             out_ready;
  vda_vec_t         out_vec;
  logic             out_last;

  modport slave (
    input  in_valid, in_vec, in_rep, out_ready,
    output in_ready, out_valid, out_vec, out_last
  );

  modport master (
    output in_valid, in_vec, in_rep, out_ready,
    input  in_ready, out_valid, out_vec, out_last
  );

endinterface

// File: rtl/vda_cmd_fifo.sv
// Generic synchronous FIFO; full/empty derived from the occupancy counter.
module vda_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 21
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/vda_cmd_issue.sv
// Command staging and repeat-issue stage feeding the vda decode array.
module vda_cmd_issue
  import vda_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned REP_W = 4,
  parameter int unsigned VEC_W = 17
) (
  input  logic                        clk,
  input  logic                        rst,
  vda_cmd_issue_if.slave              bus,
  input  logic                        flush,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        busy
);

  typedef struct packed {
    logic [VEC_W-1:0] vec;
    logic [REP_W-1:0] rep;
  } cmd_t;

  cmd_t             wr_cmd, head;
  logic             push, pop, full, empty;
  logic             accept, rep_done;
  issue_state_t     state_q, state_d;
  logic [VEC_W-1:0] out_vec_q, out_vec_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  // in_ready deliberately ignores out_ready: no push when full, even with a pop.
  assign bus.in_ready = !full && !flush;
  assign push         = bus.in_valid && bus.in_ready;
  assign wr_cmd       = '{vec: bus.in_vec, rep: bus.in_rep};

  vda_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cmd_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_cmd),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign accept        = (state_q == ISSUE) && bus.out_ready;
  assign rep_done      = (rep_cnt_q == '0);
  assign bus.out_valid = (state_q == ISSUE);
  assign bus.out_last  = (state_q == ISSUE) && rep_done;
  assign bus.out_vec   = out_vec_q;
  assign busy          = (count != '0) || bus.out_valid;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: leave ISSUE only when the final repeat is taken and nothing is queued.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!empty) state_d = ISSUE;
        ISSUE:   if (accept && rep_done && empty) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage control: pop/load, repeat countdown, clear to quiescent vector.
  always_comb begin
    pop       = 1'b0;
    out_vec_d = out_vec_q;
    rep_cnt_d = rep_cnt_q;
    if (flush) begin
      out_vec_d = '0;
      rep_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            pop       = 1'b1;
            out_vec_d = head.vec;
            rep_cnt_d = head.rep;
          end
        end
        ISSUE: begin
          if (accept) begin
            if (!rep_done) begin
              rep_cnt_d = rep_cnt_q - REP_W'(1);
            end else if (!empty) begin
              pop       = 1'b1;
              out_vec_d = head.vec;
              rep_cnt_d = head.rep;
            end else begin
              out_vec_d = '0;
            end
          end
        end
        default: begin
          out_vec_d = '0;
          rep_cnt_d = '0;
        end
      endcase
    end
  end

  // Output vector and repeat counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vec_q <= '0;
      rep_cnt_q <= '0;
    end else begin
      out_vec_q <= out_vec_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end

endmodule

// File: tb/tb_vda_cmd_issue.sv
// Self-checking bench for vda_cmd_issue with a beat-stream reference model.
module tb_vda_cmd_issue;
  import vda_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned REP_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] count;
  logic       busy;

  vda_cmd_issue_if #(.REP_W(REP_W)) bus ();

  vda_cmd_issue #(.DEPTH(DEPTH), .REP_W(REP_W), .VEC_W(17)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .flush (flush),
    .count (count),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc_n = 0;
  logic [17:0] exp_q[$];
  logic [17:0] got_q[$];
  int          got_t[$];
  logic        pushed;
  logic        s_valid, s_ready, s_last;
  logic [16:0] s_vec;

  // One clock: sample before the edge, expand accepted pushes into expected beats.
  task automatic cyc();
    int rep;
    pushed = 1'b0;
    @(negedge clk);
    s_valid = bus.out_valid; s_ready = bus.out_ready;
    s_vec = bus.out_vec; s_last = bus.out_last;
    if (!rst && bus.in_valid && bus.in_ready) begin
      pushed = 1'b1;
      rep = int'(bus.in_rep);
      for (int r = 0; r <= rep; r++) exp_q.push_back({(r == rep), bus.in_vec});
    end
    if (!rst && bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_last, bus.out_vec});
      got_t.push_back(cyc_n);
    end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic present(input logic [16:0] v, input int rep);
    bus.in_valid = 1'b1;
    bus.in_vec   = v;
    bus.in_rep   = REP_W'(rep);
  endtask

  task automatic clear_model();
    exp_q.delete(); got_q.delete(); got_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_vec = '0; bus.in_rep = '0;
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_vec !== 17'h0) begin failures++; $display("FAIL rst_vec got=%h exp=0", bus.out_vec); end
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(17'($urandom), int'($urandom_range(0, 3)));
      cyc();
    end
    bus.in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL pre_rst_count got=%0d exp=3", count); end
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%b exp=1", bus.out_valid); end
    @(negedge clk); #1; rst = 1'b1; #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid got=%b exp=0", bus.out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL async_rst_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy got=%b exp=0", busy); end
    @(posedge clk); #1; rst = 1'b0;
    clear_model();
    bus.out_ready = 1'b1;
    present(17'h1_2345, 0);
    cyc();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL lat_early got=%b exp=0", bus.out_valid); end
    cyc();
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL lat_valid got=%b exp=1", bus.out_valid); end
    checks++; if (bus.out_vec !== 17'h1_2345) begin failures++; $display("FAIL lat_vec got=%h exp=12345", bus.out_vec); end
    checks++; if (bus.out_last !== 1'b1) begin failures++; $display("FAIL lat_last got=%b exp=1", bus.out_last); end
    cyc();
    checks++; if (bus.out_valid !== 1'b0 || bus.out_vec !== 17'h0 || busy !== 1'b0) begin
      failures++; $display("FAIL lat_idle got=%b/%h/%b exp=0/0/0", bus.out_valid, bus.out_vec, busy);
    end
  endtask

  task automatic test_repeat();
    logic [16:0] v;
    clear_model();
    bus.out_ready = 1'b1;
    present(17'h0_8001, 2);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_vec !== 17'h0_8001 || bus.out_last !== (i == 2)) begin
        failures++; $display("FAIL rep_beat%0d got=%b/%h/%b exp=1/08001/%b", i, bus.out_valid, bus.out_vec, bus.out_last, (i == 2));
      end
      cyc();
    end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_vec !== 17'h0) begin
      failures++; $display("FAIL rep_end got=%b/%h exp=0/00000", bus.out_valid, bus.out_vec);
    end
    clear_model();
    v = 17'($urandom) | 17'h1;
    present(v, 15);
    cyc();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 40 && busy; k++) cyc();
    checks++; if (got_q.size() != 16) begin failures++; $display("FAIL rep_max_beats got=%0d exp=16", got_q.size()); end
    else begin
      checks++; if (got_q[15] !== {1'b1, v} || got_q[14] !== {1'b0, v}) begin
        failures++; $display("FAIL rep_max_last got=%h/%h exp=%h/%h", got_q[14], got_q[15], {1'b0, v}, {1'b1, v});
      end
    end
  endtask

  task automatic test_fill();
    clear_model();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      present(17'($urandom), int'($urandom_range(0, 2)));
      cyc();
      checks++; if (pushed !== 1'b1) begin failures++; $display("FAIL fill_push%0d got=%b exp=1", i, pushed); end
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", bus.in_ready); end
    present(17'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (pushed !== 1'b0 || count !== 3'd4) begin
        failures++; $display("FAIL fill_hold got=%b/%0d exp=0/4", pushed, count);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 100 && (busy || bus.in_valid); k++) begin
      cyc();
      if (pushed) bus.in_valid = 1'b0;
    end
    checks++; if (busy !== 1'b0 || bus.in_valid !== 1'b0) begin failures++; $display("FAIL fill_drain got=%b exp=0", busy); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL fill_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fill_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    clear_model();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 60 && (busy || sent < 10); k++) begin
      if (sent < 10) present(17'($urandom), 0);
      else bus.in_valid = 1'b0;
      cyc();
      if (pushed) sent++;
    end
    bus.in_valid = 1'b0;
    checks++; if (sent != 10 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0d/%b exp=10/0", sent, busy); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_beats got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
      checks++; if (got_t[i] != got_t[0] + i) begin failures++; $display("FAIL b2b_gap%0d got=%0d exp=%0d", i, got_t[i], got_t[0] + i); end
    end
  endtask

  task automatic test_stall();
    int sent = 0;
    clear_model();
    for (int k = 0; k < 500 && (busy || sent < 6); k++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      if (!bus.in_valid && sent < 6 && $urandom_range(0, 1) == 1) present(17'($urandom), 3);
      cyc();
      if (pushed) begin sent++; bus.in_valid = 1'b0; end
      if (s_valid && !s_ready) begin
        checks++; if (bus.out_valid !== 1'b1 || bus.out_vec !== s_vec || bus.out_last !== s_last) begin
          failures++; $display("FAIL stall_hold got=%h/%b exp=%h/%b", bus.out_vec, bus.out_last, s_vec, s_last);
        end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got_q.size() != 24) begin failures++; $display("FAIL stall_beats got=%0d exp=24", got_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_model got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush();
    clear_model();
    bus.out_ready = 1'b0;
    present(17'($urandom), 2); cyc();
    for (int i = 0; i < 3; i++) begin present(17'($urandom), int'($urandom_range(0, 3))); cyc(); end
    checks++; if (count !== 3'd3 || bus.out_valid !== 1'b1 || bus.out_last !== 1'b0) begin
      failures++; $display("FAIL flush_pre got=%0d/%b/%b exp=3/1/0", count, bus.out_valid, bus.out_last);
    end
    flush = 1'b1;
    present(17'h1_5555, 0);
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got=%b exp=0", bus.in_ready); end
    cyc();
    flush = 1'b0; bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL flush_state got=%b/%0d/%b exp=0/0/0", bus.out_valid, count, busy);
    end
    checks++; if (bus.out_vec !== 17'h0 || bus.out_last !== 1'b0) begin
      failures++; $display("FAIL flush_vec got=%h/%b exp=0/0", bus.out_vec, bus.out_last);
    end
    clear_model();
    bus.out_ready = 1'b1;
    repeat (3) cyc();
    checks++; if (got_q.size() != 0 || busy !== 1'b0) begin failures++; $display("FAIL flush_drop got=%0d exp=0", got_q.size()); end
    present(17'($urandom), 1);
    for (int k = 0; k < 20 && (busy || bus.in_valid); k++) begin
      cyc();
      if (pushed) bus.in_valid = 1'b0;
    end
    checks++; if (got_q.size() != 2 || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL flush_after got=%0d exp=2", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flush_beat%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_repeat();
    test_fill();
    test_back_to_back();
    test_stall();
    test_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
